// File: rtl/scarv_cop_perm_seq.sv
// Sequential xc.pbit / xc.ipbit / xc.pbyte unit: one shared butterfly layer stepped per cycle.
// Optional build macro SCARV_COP_PERM_SKIP_EN steps only the layers enabled in cs.
module scarv_cop_perm_seq (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        perm_ivalid,
    output logic        perm_idone,
    output logic        perm_busy,
    input  logic [31:0] perm_rs1,
    input  logic [31:0] perm_rs3,
    input  logic [31:0] id_imm,
    input  logic [15:0] id_subclass,
    output logic [3:0]  perm_cpr_rd_ben,
    output logic [31:0] perm_cpr_rd_wdata,
    output logic [1:0]  o_dbg_state
);
    // Handshake: perm_ivalid is held high from accept until perm_idone. Dropping it
    // during RUN aborts the operation. perm_idone is a single-cycle pulse.
    localparam int SC_BIT  = 0;
    localparam int SC_IBIT = 1;
    localparam int SC_BYTE = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_layer;
    logic [2:0]  w_layer_nxt;
    logic [31:0] r_acc;
    logic [31:0] r_mask;
    logic [4:0]  r_cs;
    logic        r_dir;
    logic        r_known;

    logic        w_accept;
    logic        w_is_byte;
    logic        w_is_ibit;
    logic        w_is_bit;
    logic [4:0]  w_dist;
    logic [31:0] w_bfly;
    logic [31:0] w_pbyte;
    logic [7:0]  w_rs1_byte [4];
    logic        w_res_en;
    logic        w_unused_bits;

    assign w_unused_bits = ^{id_imm[31:10], id_imm[1:0], id_subclass[15:3]};

    // Subclass priority when several bits are set: BYTE > IBIT > BIT.
    assign w_is_byte = id_subclass[SC_BYTE];
    assign w_is_ibit = !id_subclass[SC_BYTE] && id_subclass[SC_IBIT];
    assign w_is_bit  = !id_subclass[SC_BYTE] && !id_subclass[SC_IBIT] && id_subclass[SC_BIT];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_rs1_byte[i] = perm_rs1[8*i +: 8];
        end
    end

    assign w_pbyte = {w_rs1_byte[id_imm[3:2]], w_rs1_byte[id_imm[5:4]],
                      w_rs1_byte[id_imm[7:6]], w_rs1_byte[id_imm[9:8]]};

    // Inverse permutation walks the same layers with distances reversed.
    assign w_dist = r_dir ? (5'd1 << (3'd4 - r_layer)) : (5'd1 << r_layer);

    always_comb begin
        for (int j = 0; j < 32; j++) begin
            w_bfly[j] = (!r_cs[r_layer] || r_mask[j]) ? r_acc[j] : r_acc[5'(j) ^ w_dist];
        end
    end

`ifdef SCARV_COP_PERM_SKIP_EN
    logic       w_first_found;
    logic [2:0] w_first_layer;
    logic       w_next_found;
    logic [2:0] w_next_layer;

    // Descending scans so the lowest qualifying layer wins.
    always_comb begin
        w_first_found = 1'b0;
        w_first_layer = 3'd0;
        w_next_found  = 1'b0;
        w_next_layer  = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (id_imm[5+k]) begin
                w_first_found = 1'b1;
                w_first_layer = 3'(k);
            end
            if ((3'(k) > r_layer) && r_cs[k]) begin
                w_next_found = 1'b1;
                w_next_layer = 3'(k);
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_layer;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (perm_ivalid) begin
                    w_accept = 1'b1;
                    if (w_is_bit || w_is_ibit) begin
`ifdef SCARV_COP_PERM_SKIP_EN
                        w_state_nxt = w_first_found ? S_RUN : S_DONE;
                        w_layer_nxt = w_first_layer;
`else
                        w_state_nxt = S_RUN;
                        w_layer_nxt = 3'd0;
`endif
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (!perm_ivalid) begin
                    w_state_nxt = S_IDLE;
                    w_layer_nxt = 3'd0;
`ifdef SCARV_COP_PERM_SKIP_EN
                end else if (w_next_found) begin
                    w_layer_nxt = w_next_layer;
`else
                end else if (r_layer != 3'd4) begin
                    w_layer_nxt = r_layer + 3'd1;
`endif
                end else begin
                    w_state_nxt = S_DONE;
                    w_layer_nxt = 3'd0;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state <= S_IDLE;
            r_layer <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_layer <= w_layer_nxt;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_acc   <= 32'd0;
            r_mask  <= 32'd0;
            r_cs    <= 5'd0;
            r_dir   <= 1'b0;
            r_known <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_is_byte ? w_pbyte : perm_rs3;
            r_mask  <= perm_rs1;
            r_cs    <= id_imm[9:5];
            r_dir   <= w_is_ibit;
            r_known <= w_is_byte || w_is_ibit || w_is_bit;
        end else if ((r_state == S_RUN) && perm_ivalid) begin
            r_acc <= w_bfly;
        end
    end

    assign w_res_en          = (r_state == S_DONE) && r_known;
    assign perm_idone        = (r_state == S_DONE);
    assign perm_busy         = (r_state != S_IDLE);
    assign perm_cpr_rd_ben   = w_res_en ? 4'hF : 4'h0;
    assign perm_cpr_rd_wdata = w_res_en ? r_acc : 32'd0;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_scarv_cop_perm_seq.sv
// Bench for scarv_cop_perm_seq: directed table, randomized ops against a bit-level model,
// and hand-written abort / reset / back-to-back sequences.
module tb_scarv_cop_perm_seq;
    localparam logic [15:0] SC_BIT  = 16'h0001;
    localparam logic [15:0] SC_IBIT = 16'h0002;
    localparam logic [15:0] SC_BYTE = 16'h0004;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        perm_ivalid;
    logic        perm_idone;
    logic        perm_busy;
    logic [31:0] perm_rs1;
    logic [31:0] perm_rs3;
    logic [31:0] id_imm;
    logic [15:0] id_subclass;
    logic [3:0]  perm_cpr_rd_ben;
    logic [31:0] perm_cpr_rd_wdata;
    logic [1:0]  unused_dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [15:0] sub;
        logic [31:0] rs1;
        logic [31:0] rs3;
        logic [31:0] imm;
        logic [31:0] wdata;
        logic [3:0]  ben;
    } vec_t;

    vec_t vecs[9];

    scarv_cop_perm_seq dut (
        .g_clk             (g_clk),
        .g_reset           (g_reset),
        .perm_ivalid       (perm_ivalid),
        .perm_idone        (perm_idone),
        .perm_busy         (perm_busy),
        .perm_rs1          (perm_rs1),
        .perm_rs3          (perm_rs3),
        .id_imm            (id_imm),
        .id_subclass       (id_subclass),
        .perm_cpr_rd_ben   (perm_cpr_rd_ben),
        .perm_cpr_rd_wdata (perm_cpr_rd_wdata),
        .o_dbg_state       (unused_dbg_state)
    );

    // Clock / reset
    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: whole-word view of the permutation rules.
    function automatic logic [35:0] perm_model(input logic [15:0] sub, input logic [31:0] rs1,
                                               input logic [31:0] rs3, input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] nw;
        int b;
        int d;
        w = 32'd0;
        if (sub[2]) begin
            for (int i = 0; i < 4; i++) begin
                b = int'((imm >> (8 - 2*i)) & 32'd3);
                w = w | (((rs1 >> (8*b)) & 32'hFF) << (8*i));
            end
            return {4'hF, w};
        end else if (sub[1] || sub[0]) begin
            w = rs3;
            for (int k = 0; k < 5; k++) begin
                if (imm[5+k]) begin
                    d = sub[1] ? (1 << (4-k)) : (1 << k);
                    for (int j = 0; j < 32; j++) nw[j] = rs1[j] ? w[j] : w[j ^ d];
                    w = nw;
                end
            end
            return {4'hF, w};
        end
        return 36'd0;
    endfunction

    function automatic int lat_model(input logic [15:0] sub, input logic [31:0] imm);
        if (sub[2] || !(sub[1] || sub[0])) return 1;
`ifdef SCARV_COP_PERM_SKIP_EN
        return 1 + $countones(imm[9:5]);
`else
        return (imm[9:5] === 5'bxxxxx) ? 0 : 6;
`endif
    endfunction

    // Driver: issue one op in an IDLE cycle (cycle 0), hold ivalid until idone.
    task automatic run_op(input string name, input logic [15:0] sub, input logic [31:0] rs1,
                          input logic [31:0] rs3, input logic [31:0] imm,
                          input logic [31:0] exp_w, input logic [3:0] exp_b);
        int seen;
        int bad;
        int exp_lat;
        logic [31:0] q_w;
        seen    = 0;
        bad     = 0;
        exp_lat = lat_model(sub, imm);
        exp_q.push_back(exp_w);
        @(negedge g_clk);
        id_subclass = sub;
        perm_rs1    = rs1;
        perm_rs3    = rs3;
        id_imm      = imm;
        perm_ivalid = 1'b1;
        for (int n = 1; n <= 20 && seen == 0; n++) begin
            @(posedge g_clk); #1;
            if (n == 1) begin
                perm_rs1    = $urandom;
                perm_rs3    = $urandom;
                id_imm      = $urandom;
                id_subclass = 16'($urandom);
            end
            if (perm_idone) begin
                seen        = n;
                perm_ivalid = 1'b0;
                q_w = exp_q.pop_front();
                chk({name, " wdata"}, perm_cpr_rd_wdata, q_w);
                chk({name, " ben"}, 32'(perm_cpr_rd_ben), 32'(exp_b));
            end else if (!perm_busy || perm_cpr_rd_ben != 4'h0 || perm_cpr_rd_wdata != 32'd0) begin
                bad++;
            end
        end
        if (seen == 0) begin
            n_total++;
            $display("FAIL %s timeout: no idone within 20 cycles, expected at cycle %0d", name, exp_lat);
            perm_ivalid = 1'b0;
            if (exp_q.size() > 0) q_w = exp_q.pop_front();
        end else begin
            chk({name, " latency"}, 32'(seen), 32'(exp_lat));
        end
        chk({name, " quiet"}, 32'(bad), 32'd0);
        @(posedge g_clk); #1;
        chk({name, " idle"}, 32'(perm_busy), 32'd0);
    endtask

    initial begin
        logic [35:0] m;
        logic [15:0] sub;
        logic [31:0] rs1;
        logic [31:0] rs3;
        logic [31:0] imm;
        int idc;

        vecs[0] = '{SC_BIT,   32'h00000000, 32'h00000001, 32'h3E0, 32'h80000000, 4'hF};
        vecs[1] = '{SC_IBIT,  32'h00000000, 32'h00000001, 32'h020, 32'h00010000, 4'hF};
        vecs[2] = '{SC_BYTE,  32'h44332211, 32'h12345678, 32'h390, 32'h11223344, 4'hF};
        vecs[3] = '{SC_BIT,   32'h00000001, 32'h00000003, 32'h020, 32'h00000003, 4'hF};
        vecs[4] = '{16'h0008, 32'h44332211, 32'hFFFFFFFF, 32'h3E0, 32'h00000000, 4'h0};
        vecs[5] = '{16'h0007, 32'h44332211, 32'h00000001, 32'h390, 32'h11223344, 4'hF};
        vecs[6] = '{16'h0003, 32'h00000000, 32'h00000001, 32'h020, 32'h00010000, 4'hF};
        vecs[7] = '{SC_BIT,   32'h00000000, 32'hDEADBEEF, 32'h000, 32'hDEADBEEF, 4'hF};
        vecs[8] = '{SC_IBIT,  32'h00000000, 32'h00000001, 32'h3E0, 32'h80000000, 4'hF};

        g_reset     = 1'b1;
        perm_ivalid = 1'b0;
        perm_rs1    = 32'd0;
        perm_rs3    = 32'd0;
        id_imm      = 32'd0;
        id_subclass = 16'd0;
        repeat (3) @(posedge g_clk);
        #1;
        chk("reset idone", 32'(perm_idone), 32'd0);
        chk("reset busy", 32'(perm_busy), 32'd0);
        chk("reset ben", 32'(perm_cpr_rd_ben), 32'd0);
        chk("reset wdata", perm_cpr_rd_wdata, 32'd0);
        @(negedge g_clk);
        g_reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].rs1, vecs[i].rs3, vecs[i].imm,
                   vecs[i].wdata, vecs[i].ben);
        end

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       sub = SC_BIT;
                1:       sub = SC_IBIT;
                2:       sub = SC_BYTE;
                default: sub = 16'($urandom);
            endcase
            rs1 = $urandom;
            rs3 = $urandom;
            imm = $urandom;
            m   = perm_model(sub, rs1, rs3, imm);
            run_op($sformatf("rnd%0d", i), sub, rs1, rs3, imm, m[31:0], m[35:32]);
        end

        // Abort: ivalid low during cycle 3 of a pbit op.
        @(negedge g_clk);
        id_subclass = SC_BIT; perm_rs1 = 32'd0; perm_rs3 = 32'd1; id_imm = 32'h3E0;
        perm_ivalid = 1'b1;
        idc = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge g_clk); #1;
            if (n == 3) perm_ivalid = 1'b0;
            if (perm_idone || perm_cpr_rd_ben != 4'h0) idc++;
            if (n == 2) chk("abort busy run", 32'(perm_busy), 32'd1);
            if (n == 4) chk("abort busy idle", 32'(perm_busy), 32'd0);
        end
        chk("abort no idone", 32'(idc), 32'd0);

        // Reset pulsed during cycle 2 of a pbit op.
        @(negedge g_clk);
        id_subclass = SC_BIT; perm_rs1 = 32'd0; perm_rs3 = 32'd1; id_imm = 32'h3E0;
        perm_ivalid = 1'b1;
        idc = 0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge g_clk); #1;
            if (perm_idone) idc++;
            if (n == 1) chk("rst busy before", 32'(perm_busy), 32'd1);
            if (n == 2) begin
                g_reset     = 1'b1;
                perm_ivalid = 1'b0;
            end
            if (n == 3) begin
                chk("rst mid idone", 32'(perm_idone), 32'd0);
                chk("rst mid busy", 32'(perm_busy), 32'd0);
                chk("rst mid ben", 32'(perm_cpr_rd_ben), 32'd0);
                chk("rst mid wdata", perm_cpr_rd_wdata, 32'd0);
                g_reset = 1'b0;
            end
        end
        chk("rst no idone", 32'(idc), 32'd0);

        // Back-to-back pbyte with ivalid held: idone at cycles 1 and 3.
        @(negedge g_clk);
        id_subclass = SC_BYTE; perm_rs1 = 32'h44332211; id_imm = 32'h390;
        perm_ivalid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge g_clk); #1;
            chk($sformatf("b2b idone c%0d", n), 32'(perm_idone), (n == 1 || n == 3) ? 32'd1 : 32'd0);
            if (n == 1) begin
                chk("b2b wdata first", perm_cpr_rd_wdata, 32'h11223344);
                perm_rs1 = 32'h87654321;
                id_imm   = 32'h06C;
            end
            if (n == 3) begin
                chk("b2b wdata second", perm_cpr_rd_wdata, 32'h87654321);
                perm_ivalid = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
